// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide unit controller: fixed-latency mult/div sequencing,
// mthi/mtlo writes, flush on cancel, and E-stage stall generation.
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  op_e           op_q;
  logic [31:0]   a_q, b_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;

  // Result datapath, driven only from the latched operands
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0] q_u, r_u;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    prod   = '0;
    a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
    b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
    b_safe = (b_q == '0) ? 32'd1 : b_q;
    q_u    = a_q / b_safe;
    r_u    = a_q % b_safe;
    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000
    q_mag  = (b_q == '0) ? '0 : (a_mag / b_mag);
    r_mag  = (b_q == '0) ? '0 : (a_mag % b_mag);
    case (op_q)
      OP_MULT: begin
        prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        prod   = {32'd0, a_q} * {32'd0, b_q};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_we = 1'b1;
      end
      OP_DIV: begin
        res_lo = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi = a_q[31] ? (~r_mag + 32'd1) : r_mag;
        res_we = (b_q != '0);
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
        res_we = (b_q != '0);
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                a_q     <= rs;
                b_q     <= rt;
                op_q    <= op_e'(op);
                cnt_q   <= op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
                state_q <= RUN;
                busy_q  <= 1'b1;
              end
              3'd4:    hi_q <= rs;
              3'd5:    lo_q <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q | (start & ~op[2] & ~cancel);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
